// File: rtl/bw_io_impctl_updsched.sv
// bw_io_impctl_updsched
//
// Schedules impedance-calibration updates for an I/O pad. An update runs
// when software requests one, a request is pending, or the automatic
// holdoff timer has expired. Each update enables the calibration pad,
// waits for it to settle, and takes NSAMP comparator samples (one every DIV
// clocks). It then moves the 8-bit code one step toward the majority result.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-high reset
//   upd_req      software update request, sampled each clk
//   auto_en      enable periodic automatic updates
//   bypass_in    force calibration bypass (aborts any update in flight)
//   cmp_hi       pad comparator result, valid while samp_en=1
//   code         impedance code to the pad drivers
//   upd_pulse    one-cycle strobe, new code valid
//   avgcntr_rst  one-cycle reset for the external averaging counter
//   samp_en      comparator sample strobe
//   oe_out       calibration pad output enable
//   bypass       bypass_in delayed by one clk
//   busy         high whenever an update is in progress
module bw_io_impctl_updsched #(
  parameter int DIV     = 4,
  parameter int NSAMP   = 8,
  parameter int SETTLE  = 16,
  parameter int HOLDOFF = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_req,
  input  logic       auto_en,
  input  logic       bypass_in,
  input  logic       cmp_hi,
  output logic [7:0] code,
  output logic       upd_pulse,
  output logic       avgcntr_rst,
  output logic       samp_en,
  output logic       oe_out,
  output logic       bypass,
  output logic       busy
);

  // One counter serves both the settle interval and the DIV phase in SAMPLE.
  localparam int CMAX = (SETTLE > DIV) ? SETTLE : DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(NSAMP + 1);
  localparam int HW   = $clog2(HOLDOFF + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DIV_LAST    = CW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST   = SW'(NSAMP - 1);
  localparam logic [SW-1:0] HALF        = SW'(NSAMP / 2);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLDOFF);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_UPDATE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] div_nxt;
  logic [SW-1:0] samp_cnt;
  logic [SW-1:0] ones;
  logic [HW-1:0] holdoff;
  logic          pending;
  logic          trigger;

  // The holdoff timer gates only automatic starts; explicit or pending
  // requests always go.
  assign trigger = upd_req | pending | (auto_en & (holdoff == '0));

  // DIV phase of the next SAMPLE cycle; samp_en is registered from it so the
  // strobe lands on the last cycle of each DIV group.
  assign div_nxt = (cnt == DIV_LAST) ? '0 : cnt + CW'(1);

  // Whole scheduler: state, counters and all registered outputs. A bypass in
  // any busy state drops straight back to IDLE without touching the code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      code        <= 8'h80;
      holdoff     <= '0;
      pending     <= 1'b0;
      cnt         <= '0;
      samp_cnt    <= '0;
      ones        <= '0;
      upd_pulse   <= 1'b0;
      avgcntr_rst <= 1'b0;
      samp_en     <= 1'b0;
      oe_out      <= 1'b0;
      bypass      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bypass      <= bypass_in;
      upd_pulse   <= 1'b0;
      avgcntr_rst <= 1'b0;
      samp_en     <= 1'b0;

      // Requests during an update merge into a single pending flag; the
      // assignments below take precedence when the flag must clear.
      if (upd_req && state != ST_IDLE) pending <= 1'b1;

      if (state != ST_IDLE && bypass_in) begin
        state   <= ST_IDLE;
        oe_out  <= 1'b0;
        busy    <= 1'b0;
        pending <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (holdoff != '0) holdoff <= holdoff - HW'(1);
            if (!bypass_in && trigger) begin
              state       <= ST_SETTLE;
              avgcntr_rst <= 1'b1;
              oe_out      <= 1'b1;
              busy        <= 1'b1;
              pending     <= 1'b0;
              cnt         <= '0;
              samp_cnt    <= '0;
              ones        <= '0;
            end
          end

          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state   <= ST_SAMPLE;
              cnt     <= '0;
              samp_en <= (DIV == 1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          ST_SAMPLE: begin
            if (samp_en) begin
              ones     <= ones + SW'(cmp_hi);
              samp_cnt <= samp_cnt + SW'(1);
            end
            if (samp_en && samp_cnt == SAMP_LAST) begin
              state  <= ST_UPDATE;
              oe_out <= 1'b0;
            end else begin
              cnt     <= div_nxt;
              samp_en <= (div_nxt == DIV_LAST);
            end
          end

          ST_UPDATE: begin
            // Majority high means the pad is too strong: step the code down.
            if (ones > HALF) begin
              if (code != 8'h00) code <= code - 8'h01;
            end else if (ones < HALF) begin
              if (code != 8'hFF) code <= code + 8'h01;
            end
            upd_pulse <= 1'b1;
            holdoff   <= HOLD_LOAD;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
